instruction_cache: RTL and testbench
====================================

# instruction_cache

Direct-mapped instruction cache between the Fetcher and the MemoryController's instruction-fetch port. It serves the Fetcher's word requests from on-chip lines. On a miss it refills a whole 4-word line through the MemoryController's word interface. It abandons any in-flight refill on ROB rollback.

## Interface

**Parameters**
- INDEX_BITS, default 5: line index width; the cache has 2^INDEX_BITS lines.
- Line size is fixed at 4 words (16 bytes). Tag width = 28 - INDEX_BITS.

**Ports** (`name  direction  width  meaning`)
- clk  in  1  system clock; the block uses one clock.
- rst  in  1  reset, asynchronous and active-low.
- rdy  in  1  global ready; when low, all state and outputs freeze.
- rob_rollback_in  in  1  misprediction flush from the ReorderBuffer.
- fet_request_in  in  1  Fetcher requests the word at fet_address_in.
- fet_address_in  in  32  fetch address; bits [1:0] are always 0.
- fet_ready_out  out  1  one-cycle pulse: fet_instruction_out is valid.
- fet_instruction_out  out  32  returned instruction word.
- mc_request_out  out  1  word read request to the MemoryController.
- mc_address_out  out  32  word address of the current refill beat.
- mc_ready_in  in  1  one-cycle pulse: mc_instruction_in is valid.
- mc_instruction_in  in  32  word returned by the MemoryController.

## Operation

**Address split**
- [3:2] word offset.
- [3+INDEX_BITS:4] index.
- [31:4+INDEX_BITS] tag.

**Storage**
- Per line: valid bit, tag, 4 data words.
- Only reset clears the valid bits. Rollback does not.

**FSM states:** IDLE, RESP, REFILL_WAIT, REFILL_GAP.

- **IDLE**
  - If fet_request_in is high, register the address and look up the line.
  - On a hit (valid and tag match): fet_instruction_out <= word, fet_ready_out <= 1, go to RESP.
  - On a miss:
    - clear the line's valid bit;
    - set beat counter k = 0;
    - mc_address_out <= {addr[31:4], 4'b0};
    - mc_request_out <= 1;
    - go to REFILL_WAIT.
- **RESP**
  - fet_ready_out <= 0; go to IDLE.
  - fet_request_in is ignored this cycle, because the Fetcher is still seeing the ready pulse.
- **REFILL_WAIT**
  - mc_request_out and mc_address_out are held stable.
  - On mc_ready_in: store the word at offset k and set mc_request_out <= 0.
  - If k == 3:
    - write the tag, set the valid bit;
    - fet_instruction_out <= the stored word at the requested offset (take it from mc_instruction_in if the offset is 3);
    - fet_ready_out <= 1; go to RESP.
  - Otherwise: k <= k+1, go to REFILL_GAP.
- **REFILL_GAP**
  - mc_address_out <= mc_address_out + 4; mc_request_out <= 1; go to REFILL_WAIT.

**Fetcher contract**
- The Fetcher holds fet_request_in and fet_address_in stable until fet_ready_out or rollback.
- Behaviour is unspecified if it changes them earlier.

**Rollback** (highest priority, any state)
- Next edge: state <= IDLE, fet_ready_out <= 0, mc_request_out <= 0, k <= 0.
- A line under refill stays invalid.
- An mc_ready_in that arrives while IDLE is ignored.

**rdy low**
- No state, storage or output changes.
- Rollback is also not acted upon until rdy returns.

**Reset values**
- fet_ready_out = 0, fet_instruction_out = 0.
- mc_request_out = 0, mc_address_out = 0.
- All valid bits = 0, state = IDLE.

## Timing

- All outputs are registered.
- Hit: request sampled at edge N, fet_ready_out high in cycle N+1 only. Throughput is 1 hit per 2 cycles.
- Miss: mc_request_out rises after the sampling edge. Each beat lasts (MemoryController latency + 1 gap cycle). fet_ready_out pulses on the edge after the 4th mc_ready_in.
- mc_request_out is always low for at least one cycle between beats.
- Rollback in the same cycle as mc_ready_in: the rollback wins and the word is discarded.
- Rollback in the same cycle as a hit lookup: no fet_ready_out.
- Asynchronous reset mid-refill: outputs go to reset values immediately and all lines become invalid.

## Test plan

- **Cold miss at 0x0000:** MemoryController returns 0x00000013, 0x00100093, 0x00200113, 0x00300193 at 1-cycle latency. Required: requests to 0x0, 0x4, 0x8, 0xC, each separated by one low cycle; after the 4th beat, fet_ready_out pulses once with 0x00000013.
- **Hit after fill:** request 0x0008. Required: fet_ready_out in the next cycle with 0x00200113; mc_request_out stays 0.
- **Conflict eviction (INDEX_BITS=5):** request 0x0200 (index 0, different tag). Required: refill of 0x200-0x20C. A following request to 0x0004 must miss again and refill 0x0-0xC.
- **Rollback after 2 beats of a refill at 0x0040:**
  - Required: mc_request_out is 0 the next cycle and fet_ready_out never pulses.
  - A late mc_ready_in is ignored.
  - A new request to 0x0044 performs a full 4-beat refill from 0x0040.
- **rdy low for 5 cycles during REFILL_WAIT while mc_ready_in pulses:** required: no state change; mc_address_out is unchanged when rdy returns.
- **Async reset (rst=0) mid-refill:** required: all outputs 0 immediately; a subsequent request to a previously filled address misses.

Source files
------------

// File: rtl/instruction_cache_if.sv
// Fetcher and MemoryController signals seen by the instruction cache.
interface instruction_cache_if;
    logic        fet_request_in;
    logic [31:0] fet_address_in;
    logic        fet_ready_out;
    logic [31:0] fet_instruction_out;
    logic        mc_request_out;
    logic [31:0] mc_address_out;
    logic        mc_ready_in;
    logic [31:0] mc_instruction_in;

    // Cache side.
    modport slave (
        input  fet_request_in, fet_address_in, mc_ready_in, mc_instruction_in,
        output fet_ready_out, fet_instruction_out, mc_request_out, mc_address_out
    );

    // Fetcher / MemoryController side.
    modport master (
        output fet_request_in, fet_address_in, mc_ready_in, mc_instruction_in,
        input  fet_ready_out, fet_instruction_out, mc_request_out, mc_address_out
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with 4-word lines, refilled one word per
// MemoryController beat; a ROB rollback abandons any refill in flight.
module instruction_cache #(
    parameter int unsigned INDEX_BITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rob_rollback_in,
    instruction_cache_if.slave bus
);
    localparam int unsigned NUM_LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS  = 28 - INDEX_BITS;
    localparam int unsigned WORDS     = 4;
    localparam int unsigned IDX_LO    = 4;
    localparam int unsigned TAG_LO    = 4 + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        REFILL_WAIT,
        REFILL_GAP
    } state_e;

    state_e               state_q, state_d;
    logic                 fet_ready_q, fet_ready_d;
    logic [31:0]          fet_instr_q, fet_instr_d;
    logic                 mc_req_q, mc_req_d;
    logic [31:0]          mc_addr_q, mc_addr_d;
    logic [1:0]           beat_q, beat_d;
    logic [31:2]          req_addr_q, req_addr_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;

    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS];

    logic                  data_we_c;
    logic                  tag_we_c;
    logic                  hit_c;
    logic [INDEX_BITS-1:0] in_idx_c;
    logic [TAG_BITS-1:0]   in_tag_c;
    logic [1:0]            in_off_c;
    logic [INDEX_BITS-1:0] fill_idx_c;
    logic [TAG_BITS-1:0]   fill_tag_c;
    logic [1:0]            fill_off_c;
    logic                  unused_c;

    // Address fields for the incoming lookup and for the line under refill.
    assign in_idx_c   = bus.fet_address_in[TAG_LO-1:IDX_LO];
    assign in_tag_c   = bus.fet_address_in[31:TAG_LO];
    assign in_off_c   = bus.fet_address_in[3:2];
    assign fill_idx_c = req_addr_q[TAG_LO-1:IDX_LO];
    assign fill_tag_c = req_addr_q[31:TAG_LO];
    assign fill_off_c = req_addr_q[3:2];
    assign hit_c      = valid_q[in_idx_c] && (tag_q[in_idx_c] == in_tag_c);
    assign unused_c   = ^bus.fet_address_in[1:0];

    // Next-state and output logic; rdy low holds everything, rollback overrides.
    always_comb begin
        state_d     = state_q;
        fet_ready_d = fet_ready_q;
        fet_instr_d = fet_instr_q;
        mc_req_d    = mc_req_q;
        mc_addr_d   = mc_addr_q;
        beat_d      = beat_q;
        req_addr_d  = req_addr_q;
        valid_d     = valid_q;
        data_we_c   = 1'b0;
        tag_we_c    = 1'b0;

        if (rdy && rob_rollback_in) begin
            state_d     = IDLE;
            fet_ready_d = 1'b0;
            mc_req_d    = 1'b0;
            beat_d      = 2'd0;
        end else if (rdy) begin
            case (state_q)
                IDLE: begin
                    fet_ready_d = 1'b0;
                    if (bus.fet_request_in) begin
                        req_addr_d = bus.fet_address_in[31:2];
                        if (hit_c) begin
                            fet_instr_d = data_q[in_idx_c][in_off_c];
                            fet_ready_d = 1'b1;
                            state_d     = RESP;
                        end else begin
                            valid_d[in_idx_c] = 1'b0;
                            beat_d            = 2'd0;
                            mc_addr_d         = {bus.fet_address_in[31:4], 4'b0000};
                            mc_req_d          = 1'b1;
                            state_d           = REFILL_WAIT;
                        end
                    end
                end
                RESP: begin
                    fet_ready_d = 1'b0;
                    state_d     = IDLE;
                end
                REFILL_WAIT: begin
                    if (bus.mc_ready_in) begin
                        data_we_c = 1'b1;
                        mc_req_d  = 1'b0;
                        if (beat_q == 2'd3) begin
                            // Last beat is still in flight to storage, so forward it.
                            tag_we_c            = 1'b1;
                            valid_d[fill_idx_c] = 1'b1;
                            fet_instr_d         = (fill_off_c == 2'd3) ? bus.mc_instruction_in
                                                                       : data_q[fill_idx_c][fill_off_c];
                            fet_ready_d         = 1'b1;
                            state_d             = RESP;
                        end else begin
                            beat_d  = beat_q + 2'd1;
                            state_d = REFILL_GAP;
                        end
                    end
                end
                REFILL_GAP: begin
                    mc_addr_d = mc_addr_q + 32'd4;
                    mc_req_d  = 1'b1;
                    state_d   = REFILL_WAIT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fet_ready_q <= 1'b0;
            fet_instr_q <= 32'd0;
            mc_req_q    <= 1'b0;
            mc_addr_q   <= 32'd0;
            beat_q      <= 2'd0;
            req_addr_q  <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            fet_ready_q <= fet_ready_d;
            fet_instr_q <= fet_instr_d;
            mc_req_q    <= mc_req_d;
            mc_addr_q   <= mc_addr_d;
            beat_q      <= beat_d;
            req_addr_q  <= req_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data storage; validity alone decides whether contents are used.
    always_ff @(posedge clk) begin
        if (data_we_c) begin
            data_q[fill_idx_c][beat_q] <= bus.mc_instruction_in;
        end
        if (tag_we_c) begin
            tag_q[fill_idx_c] <= fill_tag_c;
        end
    end

    assign bus.fet_ready_out       = fet_ready_q;
    assign bus.fet_instruction_out = fet_instr_q;
    assign bus.mc_request_out      = mc_req_q;
    assign bus.mc_address_out      = mc_addr_q;
endmodule

// File: tb/tb_instruction_cache.sv
// Randomized bench for instruction_cache against a line-level reference model
// and a behavioural MemoryController with configurable latency.
module tb_instruction_cache;
    localparam int unsigned INDEX_BITS = 5;
    localparam int unsigned NUM_LINES  = 1 << INDEX_BITS;

    logic clk;
    logic rst;
    logic rdy;
    logic rollback;

    instruction_cache_if bus ();

    instruction_cache #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .rob_rollback_in (rollback),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Backing memory: test-plan words at 0x0-0xC, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00000013;
            32'h4:   return 32'h00100093;
            32'h8:   return 32'h00200113;
            32'hC:   return 32'h00300193;
            default: return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
        endcase
    endfunction

    // Reference model: which memory line each cache slot currently holds.
    bit          m_valid [NUM_LINES];
    logic [31:0] m_tag   [NUM_LINES];

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) % NUM_LINES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (4 + INDEX_BITS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
    endfunction

    // MemoryController model: one response per request assertion, mc_lat cycles later.
    int          mc_lat;
    int          mc_rearm;
    logic [31:0] beat_log [$];

    initial begin
        int          seen;
        int          wait_n;
        int          rearm_seen;
        logic [31:0] a;
        seen = 0; wait_n = 0; rearm_seen = 0; a = 32'd0;
        bus.mc_ready_in       = 1'b0;
        bus.mc_instruction_in = 32'd0;
        forever begin
            @(negedge clk);
            bus.mc_ready_in = 1'b0;
            if (mc_rearm != rearm_seen) begin
                rearm_seen = mc_rearm;
                seen       = 0;
                wait_n     = 0;
            end
            if (!bus.mc_request_out) seen = 0;
            if (wait_n > 0) begin
                wait_n--;
                if (wait_n == 0) begin
                    bus.mc_ready_in       = 1'b1;
                    bus.mc_instruction_in = mem_word(a);
                end
            end else if (bus.mc_request_out && seen == 0) begin
                seen = 1;
                a    = bus.mc_address_out;
                beat_log.push_back(a);
                if (mc_lat == 0) begin
                    bus.mc_ready_in       = 1'b1;
                    bus.mc_instruction_in = mem_word(a);
                end else begin
                    wait_n = mc_lat;
                end
            end
        end
    end

    // One Fetcher request. rb_at < 0: no rollback; 0: rollback in the lookup
    // cycle; n > 0: rollback n cycles after the request was sampled.
    task automatic do_fetch(input logic [31:0] addr, input int rb_at);
        bit          hit;
        int          log0;
        int          cyc;
        bit          mc_hi;
        bit          rdy_hi;
        logic [31:0] base;
        hit    = model_hit(addr);
        log0   = beat_log.size();
        cyc    = 0;
        mc_hi  = 0;
        rdy_hi = 0;
        base   = {addr[31:4], 4'b0000};
        @(negedge clk);
        bus.fet_request_in = 1'b1;
        bus.fet_address_in = addr;
        if (rb_at >= 0) begin
            if (rb_at > 0) repeat (rb_at) @(negedge clk);
            rollback           = 1'b1;
            @(negedge clk);
            rollback           = 1'b0;
            bus.fet_request_in = 1'b0;
            check("rb_mc_req", 32'(bus.mc_request_out), 32'd0);
            check("rb_fet_ready", 32'(bus.fet_ready_out), 32'd0);
            repeat (8) begin
                @(negedge clk);
                if (bus.fet_ready_out) rdy_hi = 1;
                if (bus.mc_request_out) mc_hi = 1;
            end
            check("rb_quiet", 32'({rdy_hi, mc_hi}), 32'd0);
            if (rb_at > 0 && !hit) m_valid[line_of(addr)] = 1'b0;
            return;
        end
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.mc_request_out) mc_hi = 1;
            if (bus.fet_ready_out) break;
        end
        bus.fet_request_in = 1'b0;
        check("ready_seen", 32'(bus.fet_ready_out), 32'd1);
        check("instr", bus.fet_instruction_out, mem_word(addr));
        if (hit) begin
            check("hit_latency", 32'(cyc), 32'd1);
            check("hit_no_mc", 32'(mc_hi), 32'd0);
        end else begin
            check("miss_latency", 32'(cyc), 32'(4 * mc_lat + 8));
            check("beat_count", 32'(beat_log.size() - log0), 32'd4);
            if (beat_log.size() - log0 == 4) begin
                for (int i = 0; i < 4; i++)
                    check("beat_addr", beat_log[log0 + i], base + 32'(4 * i));
            end
            m_valid[line_of(addr)] = 1'b1;
            m_tag[line_of(addr)]   = tag_of(addr);
        end
        @(negedge clk);
        check("ready_pulse_once", 32'(bus.fet_ready_out), 32'd0);
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_pass   = 0;
        mc_lat   = 1;
        mc_rearm = 0;
        rst      = 1'b0;
        rdy      = 1'b1;
        rollback = 1'b0;
        bus.fet_request_in = 1'b0;
        bus.fet_address_in = 32'd0;
        for (int i = 0; i < int'(NUM_LINES); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'd0;
        end

        repeat (2) @(negedge clk);
        check("rst_fet_ready", 32'(bus.fet_ready_out), 32'd0);
        check("rst_fet_instr", bus.fet_instruction_out, 32'd0);
        check("rst_mc_req", 32'(bus.mc_request_out), 32'd0);
        check("rst_mc_addr", bus.mc_address_out, 32'd0);
        rst = 1'b1;

        // Cold miss, hit after fill, conflict eviction and re-refill.
        do_fetch(32'h0000_0000, -1);
        do_fetch(32'h0000_0008, -1);
        do_fetch(32'h0000_0200, -1);
        do_fetch(32'h0000_0004, -1);

        // Rollback during the third beat of a refill at 0x40; late beat arrives while idle.
        mc_lat = 3;
        do_fetch(32'h0000_0040, 12);
        do_fetch(32'h0000_0044, -1);

        // Rollback together with a hit lookup suppresses the response.
        mc_lat = 1;
        do_fetch(32'h0000_0008, 0);
        do_fetch(32'h0000_0008, -1);

        // rdy low for five cycles while the MemoryController answers.
        mc_lat = 3;
        @(negedge clk);
        bus.fet_request_in = 1'b1;
        bus.fet_address_in = 32'h0000_0300;
        @(negedge clk);
        check("frz_mc_req", 32'(bus.mc_request_out), 32'd1);
        check("frz_mc_addr", bus.mc_address_out, 32'h0000_0300);
        rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("frz_hold", {bus.mc_address_out[31:2], bus.mc_request_out, bus.fet_ready_out},
                  {30'(32'h300 >> 2), 1'b1, 1'b0});
        end
        rdy = 1'b1;
        mc_rearm++;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.fet_ready_out) break;
        end
        bus.fet_request_in = 1'b0;
        check("frz_ready", 32'(bus.fet_ready_out), 32'd1);
        check("frz_instr", bus.fet_instruction_out, mem_word(32'h0000_0300));
        m_valid[line_of(32'h300)] = 1'b1;
        m_tag[line_of(32'h300)]   = tag_of(32'h300);

        // Asynchronous reset in the middle of a refill.
        mc_lat = 2;
        @(negedge clk);
        bus.fet_request_in = 1'b1;
        bus.fet_address_in = 32'h0000_0504;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_outputs", {bus.mc_address_out[30:0], bus.mc_request_out},
              {31'd0, 1'b0});
        check("arst_fet", {bus.fet_instruction_out[30:0], bus.fet_ready_out}, {31'd0, 1'b0});
        bus.fet_request_in = 1'b0;
        for (int i = 0; i < int'(NUM_LINES); i++) m_valid[i] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        mc_rearm++;
        do_fetch(32'h0000_0008, -1);

        // Random traffic over a few lines and tags to mix hits, misses and rollbacks.
        for (int it = 0; it < 60; it++) begin
            logic [31:0] a;
            int          rb;
            mc_lat = int'($urandom_range(0, 3));
            a = (32'($urandom_range(0, 2)) << (4 + INDEX_BITS))
              | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            rb = -1;
            if (!model_hit(a) && ($urandom % 5) == 0)
                rb = int'($urandom_range(1, 32'(4 * mc_lat + 6)));
            else if (model_hit(a) && ($urandom % 10) == 0)
                rb = 0;
            do_fetch(a, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
